store_rmw_ctrl: RTL
===================

STORE_RMW_CTRL -- requirements
Module: store_rmw_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset, asynchronous and active-low; one clock domain only.
REQ-003 st_req  input  1  store request from the core, sampled only in IDLE.
REQ-004 st_word  input  1  access size: 1 = SW (full word), 0 = SB (byte).
REQ-005 st_addr  input  32  byte address of the store.
REQ-006 st_data  input  32  store data; SB uses st_data[7:0] only.
REQ-007 st_busy  output  1  high in every state except IDLE.
REQ-008 st_done  output  1  one-cycle pulse when a store completes.
REQ-009 st_err  output  1  one-cycle pulse when an SW is rejected as misaligned.
REQ-010 mem_addr  output  32  word address: {addr_q[31:2],2'b00}.
REQ-011 mem_rd  output  1  memory read strobe.
REQ-012 mem_wr  output  1  memory write strobe.
REQ-013 mem_wdata  output  32  write data.
REQ-014 mem_rdata  input  32  read data, valid when mem_ready=1 during a read.
REQ-015 mem_ready  input  1  memory completion; ends the current rd/wr cycle.

Function
REQ-016 FSM states: IDLE, RD, WR, DONE, ERR. Encoding is free.
REQ-017 In IDLE, when st_req=1: capture st_addr, st_data and st_word into addr_q, data_q and word_q on the same edge.
REQ-018 Accept transitions:
- SW with st_addr[1:0]=0 -> WR.
- SB -> RD.
- SW with st_addr[1:0]!=0 -> ERR, with no memory access.
REQ-019 RD: mem_rd=1. While mem_ready=0, stay in RD. When mem_ready=1, store the merged word in wbuf and go to WR.
REQ-020 Merge rule (little-endian):
- Lane = addr_q[1:0].
- wbuf[8*lane+7:8*lane] = data_q[7:0].
- All other bytes are taken from mem_rdata unchanged.
REQ-021 WR: mem_wr=1. mem_wdata = data_q for SW, wbuf for SB. While mem_ready=0, stay in WR. When mem_ready=1, go to DONE.
REQ-022 DONE: st_done=1 for exactly one cycle, then go to IDLE.
REQ-023 ERR: st_err=1 for exactly one cycle, then go to IDLE.
REQ-024 mem_rd and mem_wr are never high in the same cycle, and are both low in IDLE, DONE and ERR.
REQ-025 mem_addr, mem_wdata, st_busy, st_done and st_err are decoded from state and internal registers only, never directly from st_* inputs.
REQ-026 Latency with mem_ready tied high:
- SW: accept-to-st_done is 2 cycles (WR, DONE).
- SB: accept-to-st_done is 3 cycles (RD, WR, DONE).
- Each wait cycle of mem_ready=0 adds exactly one cycle.
REQ-027 st_req while st_busy=1 is ignored and not queued. The core holds st_req until it sees st_done or st_err.
REQ-028 st_req=1 in the cycle st_done or st_err is high is not accepted; acceptance happens in IDLE on the next cycle.
REQ-029 Back-to-back stores: a new request is accepted the cycle after DONE or ERR, with no extra bubble.
REQ-030 mem_ready=1 in IDLE, DONE or ERR is ignored.
REQ-031 No timeout. A stalled memory holds the FSM in RD or WR indefinitely.

Reset
REQ-032 rst_n=0 immediately forces, without waiting for clk:
- state = IDLE.
- st_busy, st_done, st_err, mem_rd, mem_wr = 0.
- addr_q, data_q, word_q, wbuf = 0.
- Therefore mem_addr = 0 and mem_wdata = 0.
REQ-033 Reset asserted in RD or WR aborts the access without completing it. No st_done is issued for the aborted store.
REQ-034 After rst_n rises, the first edge with st_req=1 in IDLE is accepted normally.

Verification
REQ-035 SB, lane 0, no wait:
- Stimulus: st_addr=0x100, st_data=0xAA, mem_rdata=0xFFFFFFFF, mem_ready=1.
- Required: mem_rd for 1 cycle at 0x100, then mem_wr with mem_wdata=0xFFFFFFAA, then st_done 3 cycles after accept.
REQ-036 SB, lane 3, with wait:
- Stimulus: st_addr=0x103, st_data=0xCC, mem_rdata=0x12345678, mem_ready low for 2 cycles in RD.
- Required: mem_wdata=0xCC345678, mem_addr=0x100, st_done 5 cycles after accept.
REQ-037 SW, aligned:
- Stimulus: st_addr=0x200, st_data=0xDEADBEEF, mem_ready=1.
- Required: no mem_rd, one mem_wr with 0xDEADBEEF, st_done 2 cycles after accept.
REQ-038 SW, misaligned:
- Stimulus: st_addr=0x202.
- Required: st_err pulse 1 cycle after accept, mem_rd=mem_wr=0 throughout, st_done never asserted.
REQ-039 Busy and back-to-back:
- Stimulus: st_req held high through an SB to lane 1 (0x101, 0xAA over 0xFFFFFFFF), then an SB to lane 2.
- Required: writes 0xFFFFAAFF then the lane-2 merge; exactly one acceptance per store; no acceptance while st_busy=1.
REQ-040 Reset mid-access:
- Stimulus: rst_n=0 in the middle of WR with mem_ready=0.
- Required: mem_wr drops to 0 asynchronously, state returns to IDLE, no st_done; the next SW completes normally.

Source files
------------

// File: rtl/store_rmw_ctrl.sv
// Store controller: SW goes straight to a word write, SB does a read-modify-write
// merge of one byte lane, and a misaligned SW is rejected without touching memory.
module store_rmw_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_req,
    input  logic        st_word,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_busy,
    output logic        st_done,
    output logic        st_err,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   data_q;
    logic            word_q;
    logic [DW-1:0]   wbuf;
    logic [DW-1:0]   merged;
    logic            accept;

    assign accept = (state == IDLE) && st_req;

    // Word address is a pure slice of the captured byte address.
    assign mem_addr = {addr_q[AW-1:2], 2'b00};

    // Little-endian byte-lane merge of the store byte into the read word.
    always_comb begin
        merged = mem_rdata;
        unique case (addr_q[1:0])
            2'd0:    merged[7:0]   = data_q[7:0];
            2'd1:    merged[15:8]  = data_q[7:0];
            2'd2:    merged[23:16] = data_q[7:0];
            default: merged[31:24] = data_q[7:0];
        endcase
    end

    // Next-state decode.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (st_req) begin
                    if (!st_word) begin
                        state_n = RD;
                    end else if (st_addr[1:0] == 2'b00) begin
                        state_n = WR;
                    end else begin
                        state_n = ERR;
                    end
                end
            end
            RD:      if (mem_ready) state_n = WR;
            WR:      if (mem_ready) state_n = DONE;
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register and state-aligned strobes, all loaded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            st_busy <= 1'b0;
            st_done <= 1'b0;
            st_err  <= 1'b0;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
        end else begin
            state   <= state_n;
            st_busy <= (state_n != IDLE);
            st_done <= (state_n == DONE);
            st_err  <= (state_n == ERR);
            mem_rd  <= (state_n == RD);
            mem_wr  <= (state_n == WR);
        end
    end

    // Request capture and merge buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            data_q <= '0;
            word_q <= 1'b0;
            wbuf   <= '0;
        end else begin
            if (accept) begin
                addr_q <= st_addr;
                data_q <= st_data;
                word_q <= st_word;
            end
            if ((state == RD) && mem_ready) begin
                wbuf <= merged;
            end
        end
    end

    // Write data: the full store word for SW, the merged word for SB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wdata <= '0;
        end else if (accept && st_word && (st_addr[1:0] == 2'b00)) begin
            mem_wdata <= st_data;
        end else if ((state == RD) && mem_ready) begin
            mem_wdata <= merged;
        end
    end

endmodule
